// File: rtl/packed_delay_line.sv
// Clock-counted delay line for packed {x,y,z} records: a ring buffer with per-entry
// valid bits, a programmable delay of 1..MAX_DELAY advancing edges, stall and flush-on-reload.
module packed_delay_line #(
  parameter int FIELD_W     = 1,
  parameter int CHANNELS    = 1,
  parameter int MAX_DELAY   = 16,
  parameter int RESET_DELAY = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                in_valid,
  input  logic [3*FIELD_W*CHANNELS-1:0]       in_data,
  input  logic                                delay_load,
  input  logic [$clog2(MAX_DELAY+1)-1:0]      delay_cfg,
  output logic                                out_valid,
  output logic [3*FIELD_W*CHANNELS-1:0]       out_data,
  output logic [$clog2(MAX_DELAY+1)-1:0]      cur_delay,
  output logic                                cfg_err
);

  localparam int DW = 3 * FIELD_W * CHANNELS;
  localparam int CW = $clog2(MAX_DELAY + 1);
  localparam int PW = $clog2(MAX_DELAY);
  localparam logic [CW-1:0] MAX_D     = CW'(MAX_DELAY);
  localparam logic [PW-1:0] LAST_SLOT = PW'(MAX_DELAY - 1);

  logic [MAX_DELAY-1:0] r_ring_valid;
  logic [DW-1:0]        r_ring_data [MAX_DELAY];
  logic [PW-1:0]        r_wptr;
  logic [CW-1:0]        r_cur_delay;
  logic                 r_cfg_err;
  logic                 r_out_valid;
  logic [DW-1:0]        r_out_data;

  logic [CW:0]   w_rd_sum;
  logic [CW:0]   w_rd_wrap;
  logic [PW-1:0] w_rd_idx;
  logic [PW-1:0] w_wptr_nxt;
  logic [CW-1:0] w_cfg_sat;
  logic          w_cfg_bad;
  logic [DW-1:0] w_wr_data;

  // Read slot = wptr - cur_delay (mod MAX_DELAY). At cur_delay == MAX_DELAY this is the
  // slot being overwritten this edge; non-blocking semantics hand us its old contents.
  always_comb begin
    w_rd_sum   = (CW+1)'(r_wptr) + (CW+1)'(MAX_DELAY) - {1'b0, r_cur_delay};
    w_rd_wrap  = (w_rd_sum >= (CW+1)'(MAX_DELAY)) ? (w_rd_sum - (CW+1)'(MAX_DELAY)) : w_rd_sum;
    w_rd_idx   = PW'(w_rd_wrap);
    w_wptr_nxt = (r_wptr == LAST_SLOT) ? '0 : (r_wptr + PW'(1));
    w_wr_data  = in_valid ? in_data : '0;
    w_cfg_bad  = (delay_cfg == '0) || (delay_cfg > MAX_D);
    if (delay_cfg == '0)
      w_cfg_sat = CW'(1);
    else if (delay_cfg > MAX_D)
      w_cfg_sat = MAX_D;
    else
      w_cfg_sat = delay_cfg;
  end

  // Data payload needs no reset: it is only ever observed through its valid bit.
  always_ff @(posedge clk) begin
    if (!rst && en)
      r_ring_data[r_wptr] <= w_wr_data;
  end

  // No back-pressure: every advancing edge accepts one record; a reload flushes in-flight ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ring_valid <= '0;
      r_wptr       <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_cur_delay  <= CW'(RESET_DELAY);
      r_cfg_err    <= 1'b0;
    end else if (delay_load) begin
      r_cur_delay  <= w_cfg_sat;
      r_cfg_err    <= w_cfg_bad;
      r_ring_valid <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      if (en) begin
        r_ring_valid[r_wptr] <= in_valid;
        r_wptr               <= w_wptr_nxt;
      end
    end else if (en) begin
      r_ring_valid[r_wptr] <= in_valid;
      r_wptr               <= w_wptr_nxt;
      r_out_valid          <= r_ring_valid[w_rd_idx];
      r_out_data           <= r_ring_valid[w_rd_idx] ? r_ring_data[w_rd_idx] : '0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign cur_delay = r_cur_delay;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_packed_delay_line.sv
// Self-checking bench for packed_delay_line: a history-queue reference model predicts
// every output from "record sampled d advancing edges ago since the last flush".
module tb_packed_delay_line;

  localparam int FIELD_W     = 4;
  localparam int CHANNELS    = 2;
  localparam int MAX_DELAY   = 16;
  localparam int RESET_DELAY = 1;
  localparam int DW = 3 * FIELD_W * CHANNELS;
  localparam int CW = $clog2(MAX_DELAY + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          delay_load = 1'b0;
  logic [CW-1:0] delay_cfg = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] cur_delay;
  logic          cfg_err;

  int total = 0;
  int bad   = 0;

  logic [DW:0]   exp_q[$];
  int            exp_d = RESET_DELAY;
  logic          exp_err = 1'b0;
  logic          exp_v = 1'b0;
  logic [DW-1:0] exp_data = '0;

  packed_delay_line #(
    .FIELD_W(FIELD_W), .CHANNELS(CHANNELS), .MAX_DELAY(MAX_DELAY), .RESET_DELAY(RESET_DELAY)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .delay_load(delay_load), .delay_cfg(delay_cfg), .out_valid(out_valid),
    .out_data(out_data), .cur_delay(cur_delay), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Driver + reference model: apply inputs, take one edge, update expectations, settle.
  task automatic step(input logic r, input logic e, input logic v, input logic [DW-1:0] dat,
                      input logic ld, input int cfg);
    logic [DW:0]   rec;
    logic [DW-1:0] md;
    rst = r; en = e; in_valid = v; in_data = dat; delay_load = ld; delay_cfg = CW'(cfg);
    @(posedge clk);
    md = v ? dat : '0;
    if (r) begin
      exp_q.delete(); exp_d = RESET_DELAY; exp_err = 1'b0; exp_v = 1'b0; exp_data = '0;
    end else if (ld) begin
      if (cfg == 0) begin exp_d = 1; exp_err = 1'b1; end
      else if (cfg > MAX_DELAY) begin exp_d = MAX_DELAY; exp_err = 1'b1; end
      else begin exp_d = cfg; exp_err = 1'b0; end
      exp_q.delete(); exp_v = 1'b0; exp_data = '0;
      if (e) exp_q.push_back({v, md});
    end else if (e) begin
      exp_q.push_back({v, md});
      if (exp_q.size() > exp_d) begin
        rec = exp_q[exp_q.size() - 1 - exp_d];
        exp_v = rec[DW];
        exp_data = rec[DW] ? rec[DW-1:0] : '0;
      end else begin
        exp_v = 1'b0; exp_data = '0;
      end
      while (exp_q.size() > MAX_DELAY + 1) void'(exp_q.pop_front());
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, '0, 0, 0);
    step(1, 1, 1, '1, 1, 7);
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || cur_delay !== CW'(RESET_DELAY) || cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got v=%b d=%h cur=%0d err=%b, want v=0 d=0 cur=%0d err=0",
               out_valid, out_data, cur_delay, cfg_err, RESET_DELAY);
    end
    step(0, 1, 1, DW'(5), 0, 0);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_first_edge0: got v=%b, want v=0", out_valid);
    end
    step(0, 1, 0, '0, 0, 0);
    total++;
    if (out_valid !== 1'b1 || out_data !== DW'(5)) begin
      bad++; $display("FAIL reset_first_edge1: got v=%b d=%h, want v=1 d=%h", out_valid, out_data, DW'(5));
    end
  endtask

  task automatic test_stream();
    int seq = 1;
    step(0, 0, 0, '0, 1, 10);
    for (int i = 0; i < 52; i++) begin
      if (i < 40) step(0, 1, 1, DW'(i + 1), 0, 0);
      else        step(0, 1, 0, '0, 0, 0);
      total++;
      if (out_valid !== exp_v || out_data !== exp_data || cur_delay !== CW'(exp_d) || cfg_err !== exp_err) begin
        bad++;
        $display("FAIL stream[%0d]: got v=%b d=%h cur=%0d err=%b, want v=%b d=%h cur=%0d err=%b",
                 i, out_valid, out_data, cur_delay, cfg_err, exp_v, exp_data, exp_d, exp_err);
      end
      if (i == 10) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== DW'(1)) begin
          bad++; $display("FAIL stream_latency: got v=%b d=%h, want v=1 d=%h", out_valid, out_data, DW'(1));
        end
      end
      if (out_valid === 1'b1) begin
        total++;
        if (out_data !== DW'(seq)) begin
          bad++; $display("FAIL stream_order: got %h, want %h", out_data, DW'(seq));
        end
        seq++;
      end
    end
    total++;
    if (seq - 1 != 40) begin
      bad++; $display("FAIL stream_count: got %0d, want 40", seq - 1);
    end
  endtask

  task automatic test_stall();
    int sent = 0;
    int got = 0;
    logic          hold_v;
    logic [DW-1:0] hold_d;
    step(0, 0, 0, '0, 1, 5);
    for (int i = 0; i < 33; i++) begin
      logic stall;
      stall = (i >= 8 && i < 11);
      hold_v = out_valid; hold_d = out_data;
      if (i < 25) begin
        step(0, !stall, 1, DW'($urandom), 0, 0);
        if (!stall) sent++;
      end else begin
        step(0, 1, 0, '0, 0, 0);
      end
      total++;
      if (out_valid !== exp_v || out_data !== exp_data || cur_delay !== CW'(exp_d) || cfg_err !== exp_err) begin
        bad++;
        $display("FAIL stall[%0d]: got v=%b d=%h cur=%0d err=%b, want v=%b d=%h cur=%0d err=%b",
                 i, out_valid, out_data, cur_delay, cfg_err, exp_v, exp_data, exp_d, exp_err);
      end
      if (stall) begin
        total++;
        if (out_valid !== hold_v || out_data !== hold_d) begin
          bad++; $display("FAIL stall_hold[%0d]: got v=%b d=%h, want v=%b d=%h", i, out_valid, out_data, hold_v, hold_d);
        end
      end else if (out_valid === 1'b1) begin
        got++;
      end
    end
    total++;
    if (got != sent) begin
      bad++; $display("FAIL stall_count: got %0d, want %0d", got, sent);
    end
  endtask

  task automatic test_flush();
    int stale = 0;
    logic [DW-1:0] marker;
    marker = DW'(24'hA5C3E1);
    step(0, 0, 0, '0, 1, 8);
    for (int i = 0; i < 6; i++) step(0, 1, 1, DW'(24'h100 + i), 0, 0);
    step(0, 1, 1, marker, 1, 3);
    for (int k = 0; k < 12; k++) begin
      step(0, 1, 0, '0, 0, 0);
      total++;
      if (out_valid !== exp_v || out_data !== exp_data || cur_delay !== CW'(exp_d) || cfg_err !== exp_err) begin
        bad++;
        $display("FAIL flush[%0d]: got v=%b d=%h cur=%0d err=%b, want v=%b d=%h cur=%0d err=%b",
                 k, out_valid, out_data, cur_delay, cfg_err, exp_v, exp_data, exp_d, exp_err);
      end
      if (k == 2) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== marker) begin
          bad++; $display("FAIL flush_marker: got v=%b d=%h, want v=1 d=%h", out_valid, out_data, marker);
        end
      end else if (out_valid === 1'b1) begin
        stale++;
      end
    end
    total++;
    if (stale != 0) begin
      bad++; $display("FAIL flush_stale: got %0d stale records, want 0", stale);
    end
  endtask

  task automatic test_cfg_range();
    int cfgs[5] = '{0, 20, 4, 7, 2};
    int want_d[5] = '{1, 16, 4, 7, 2};
    logic want_e[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step(0, (i >= 3), 1'b1, DW'($urandom), 1, cfgs[i]);
      total++;
      if (cur_delay !== CW'(want_d[i]) || cfg_err !== want_e[i] || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL cfg_range[%0d]: got cur=%0d err=%b v=%b, want cur=%0d err=%b v=0",
                 i, cur_delay, cfg_err, out_valid, want_d[i], want_e[i]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, '0, 0, 0);
      total++;
      if (out_valid !== exp_v || out_data !== exp_data || cur_delay !== CW'(exp_d) || cfg_err !== exp_err) begin
        bad++;
        $display("FAIL cfg_b2b[%0d]: got v=%b d=%h cur=%0d, want v=%b d=%h cur=%0d",
                 k, out_valid, out_data, cur_delay, exp_v, exp_data, exp_d);
      end
    end
  endtask

  task automatic test_max_delay();
    step(0, 0, 0, '0, 1, MAX_DELAY);
    for (int i = 0; i < 58; i++) begin
      if (i < 40) step(0, 1, 1'($urandom), DW'($urandom), 0, 0);
      else        step(0, 1, 0, '0, 0, 0);
      total++;
      if (out_valid !== exp_v || out_data !== exp_data || cur_delay !== CW'(exp_d) || cfg_err !== exp_err) begin
        bad++;
        $display("FAIL max_delay[%0d]: got v=%b d=%h cur=%0d, want v=%b d=%h cur=%0d",
                 i, out_valid, out_data, cur_delay, exp_v, exp_data, exp_d);
      end
    end
  endtask

  task automatic test_mask_reset();
    step(0, 0, 0, '0, 1, 4);
    step(0, 1, 0, '1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0, DW'($urandom), 0, 0);
      total++;
      if (out_valid !== 1'b0 || out_data !== '0 || exp_v !== 1'b0) begin
        bad++; $display("FAIL mask[%0d]: got v=%b d=%h, want v=0 d=0", k, out_valid, out_data);
      end
    end
    for (int i = 0; i < 5; i++) step(0, 1, 1, DW'(24'h300 + i), 0, 0);
    step(1, 1, 1, '1, 0, 0);
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || cur_delay !== CW'(RESET_DELAY) || cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got v=%b d=%h cur=%0d err=%b, want v=0 d=0 cur=%0d err=0",
               out_valid, out_data, cur_delay, cfg_err, RESET_DELAY);
    end
    for (int k = 0; k < 20; k++) begin
      step(0, 1, 0, '0, 0, 0);
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL mid_reset_leak[%0d]: got v=%b d=%h, want v=0", k, out_valid, out_data);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic r, ld;
      r  = ($urandom_range(0, 99) == 0);
      ld = ($urandom_range(0, 24) == 0);
      step(r, 1'($urandom_range(0, 3) != 0), 1'($urandom), DW'($urandom), ld, $urandom_range(0, 20));
      total++;
      if (out_valid !== exp_v || out_data !== exp_data || cur_delay !== CW'(exp_d) || cfg_err !== exp_err) begin
        bad++;
        $display("FAIL random[%0d]: got v=%b d=%h cur=%0d err=%b, want v=%b d=%h cur=%0d err=%b",
                 i, out_valid, out_data, cur_delay, cfg_err, exp_v, exp_data, exp_d, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_cfg_range();
    test_max_delay();
    test_mask_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
